// File: rtl/cpu_defs.sv
// Shared definitions for the accumulator CPU: opcode encoding (common with the ALU),
// sequencer phase numbering and the ALU-operation membership test.
package cpu_defs;

  typedef enum logic [2:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic halt;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
  } strobes_t;

  // Opcodes whose result comes back through the ALU into the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    case (op)
      ADD, AND, XOR, LDA: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/phase_counter.sv
// 3-bit wrapping phase counter with asynchronous active-low reset and a hold enable.
module phase_counter (
  input  logic       clk,
  input  logic       rst_,
  input  logic       en,
  output logic [2:0] phase
);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase <= 3'd0;
    end else if (en) begin
      phase <= phase + 3'd1;
    end
  end

endmodule

// File: rtl/seq_controller.sv
// Eight-phase fetch/execute sequencer: phase counter, halted flag and a purely
// combinational decode of phase, opcode and zero into datapath strobes.
module seq_controller
  import cpu_defs::*;
#(
  parameter int HALT_STICKY = 1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [2:0] phase
);

  localparam bit STICKY = (HALT_STICKY != 0);

  logic     halted_reg;
  logic     halted_next;
  logic     cnt_en;
  logic     op_hlt;
  logic     op_skz;
  logic     op_sto;
  logic     op_jmp;
  logic     aluop;
  strobes_t strb;

  phase_counter u_phase_counter (
    .clk   (clk),
    .rst_  (rst_),
    .en    (cnt_en),
    .phase (phase)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      halted_reg <= 1'b0;
    end else begin
      halted_reg <= halted_next;
    end
  end

  // Unknown opcode bits fall to the default arm and decode as a no-op.
  always_comb begin
    op_hlt = 1'b0;
    op_skz = 1'b0;
    op_sto = 1'b0;
    op_jmp = 1'b0;
    case (opcode)
      HLT:     op_hlt = 1'b1;
      SKZ:     op_skz = 1'b1;
      STO:     op_sto = 1'b1;
      JMP:     op_jmp = 1'b1;
      default: ;
    endcase
    aluop = is_aluop(opcode);
  end

  // The counter must already be frozen on the edge that sets halted, so phase stays at OP_ADDR.
  always_comb begin
    halted_next = halted_reg;
    if (STICKY && (phase == OP_ADDR) && op_hlt) begin
      halted_next = 1'b1;
    end
    cnt_en = !halted_next;
  end

  always_comb begin
    strb = '0;
    if (halted_reg) begin
      strb.halt = 1'b1;
    end else begin
      case (phase)
        INST_ADDR: begin
          strb.sel = 1'b1;
        end
        INST_FETCH: begin
          strb.sel = 1'b1;
          strb.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          strb.sel   = 1'b1;
          strb.rd    = 1'b1;
          strb.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          strb.inc_pc = 1'b1;
          strb.halt   = op_hlt;
        end
        OP_FETCH: begin
          strb.rd = aluop;
        end
        ALU_OP: begin
          strb.rd     = aluop;
          strb.inc_pc = op_skz && zero;
          strb.ld_pc  = op_jmp;
          strb.data_e = op_sto;
        end
        STORE: begin
          strb.rd     = aluop;
          strb.ld_ac  = aluop;
          strb.ld_pc  = op_jmp;
          strb.wr     = op_sto;
          strb.data_e = op_sto;
        end
        default: ;
      endcase
    end
  end

  assign sel    = strb.sel;
  assign rd     = strb.rd;
  assign ld_ir  = strb.ld_ir;
  assign inc_pc = strb.inc_pc;
  assign halt   = strb.halt;
  assign ld_pc  = strb.ld_pc;
  assign data_e = strb.data_e;
  assign ld_ac  = strb.ld_ac;
  assign wr     = strb.wr;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: sticky and pulse-halt instances, a vector table, hand-written
// multi-cycle sequences and a randomized run against a rule-based reference model.
module tb_seq_controller;

  logic       clk;
  logic       rst_;
  logic [2:0] opcode;
  logic       zero;

  logic       sel_s, rd_s, ld_ir_s, inc_pc_s, halt_s, ld_pc_s, data_e_s, ld_ac_s, wr_s;
  logic [2:0] phase_s;
  logic       sel_p, rd_p, ld_ir_p, inc_pc_p, halt_p, ld_pc_p, data_e_p, ld_ac_p, wr_p;
  logic [2:0] phase_p;
  logic [8:0] st_s, st_p;

  int vectors;
  int miscompares;

  seq_controller #(.HALT_STICKY(1)) dut_s (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
    .sel(sel_s), .rd(rd_s), .ld_ir(ld_ir_s), .inc_pc(inc_pc_s), .halt(halt_s),
    .ld_pc(ld_pc_s), .data_e(data_e_s), .ld_ac(ld_ac_s), .wr(wr_s), .phase(phase_s)
  );

  seq_controller #(.HALT_STICKY(0)) dut_p (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
    .sel(sel_p), .rd(rd_p), .ld_ir(ld_ir_p), .inc_pc(inc_pc_p), .halt(halt_p),
    .ld_pc(ld_pc_p), .data_e(data_e_p), .ld_ac(ld_ac_p), .wr(wr_p), .phase(phase_p)
  );

  assign st_s = {sel_s, rd_s, ld_ir_s, inc_pc_s, halt_s, ld_pc_s, data_e_s, ld_ac_s, wr_s};
  assign st_p = {sel_p, rd_p, ld_ir_p, inc_pc_p, halt_p, ld_pc_p, data_e_p, ld_ac_p, wr_p};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  typedef struct {
    logic [2:0] op;
    logic       z;
    int         ph;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] op, logic z, int ph, logic [8:0] exp);
    vec_t v;
    v.op = op; v.z = z; v.ph = ph; v.exp = exp;
    return v;
  endfunction

  // Reference: strobes written directly from the per-phase rules.
  function automatic logic [8:0] model(int ph, logic [2:0] op, logic z, bit halted_m);
    bit alu;
    logic [8:0] r;
    alu = (op >= 3'd2) && (op <= 3'd5);
    if (halted_m) return 9'b000010000;
    r[8] = (ph < 4);
    r[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    r[6] = (ph == 2) || (ph == 3);
    r[5] = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    r[4] = (ph == 4) && (op == 3'd0);
    r[3] = (op == 3'd7) && (ph >= 6);
    r[2] = (op == 3'd6) && (ph >= 6);
    r[1] = (ph == 7) && alu;
    r[0] = (ph == 7) && (op == 3'd6);
    return r;
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
               name, got[11:9], got[8:0], exp[11:9], exp[8:0]);
    end
  endtask

  task automatic pulse_reset();
    rst_ = 1'b0;
    #1;
    rst_ = 1'b1;
  endtask

  int ph_s, ph_p;
  bit h_s;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_   = 1'b0;
    opcode = 3'b010;
    zero   = 1'b0;
    #3;
    check("reset_s", {phase_s, st_s}, {3'd0, 9'b100000000});
    check("reset_p", {phase_p, st_p}, {3'd0, 9'b100000000});
    rst_ = 1'b1;

    // ---------------- table-driven vectors ----------------
    tbl.push_back(mk(3'b010, 1'b0, 0, 9'b100000000));
    tbl.push_back(mk(3'b010, 1'b0, 1, 9'b110000000));
    tbl.push_back(mk(3'b010, 1'b0, 2, 9'b111000000));
    tbl.push_back(mk(3'b010, 1'b0, 3, 9'b111000000));
    tbl.push_back(mk(3'b010, 1'b0, 4, 9'b000100000));
    tbl.push_back(mk(3'b010, 1'b0, 5, 9'b010000000));
    tbl.push_back(mk(3'b010, 1'b0, 6, 9'b010000000));
    tbl.push_back(mk(3'b010, 1'b0, 7, 9'b010000010));
    tbl.push_back(mk(3'b110, 1'b0, 5, 9'b000000000));
    tbl.push_back(mk(3'b110, 1'b0, 6, 9'b000000100));
    tbl.push_back(mk(3'b110, 1'b0, 7, 9'b000000101));
    tbl.push_back(mk(3'b001, 1'b1, 4, 9'b000100000));
    tbl.push_back(mk(3'b001, 1'b1, 6, 9'b000100000));
    tbl.push_back(mk(3'b001, 1'b0, 6, 9'b000000000));
    tbl.push_back(mk(3'b001, 1'b1, 7, 9'b000000000));
    tbl.push_back(mk(3'b111, 1'b0, 4, 9'b000100000));
    tbl.push_back(mk(3'b111, 1'b1, 6, 9'b000001000));
    tbl.push_back(mk(3'b111, 1'b0, 7, 9'b000001000));
    tbl.push_back(mk(3'b000, 1'b0, 4, 9'b000110000));
    tbl.push_back(mk(3'b101, 1'b1, 7, 9'b010000010));
    tbl.push_back(mk(3'b100, 1'b0, 6, 9'b010000000));
    tbl.push_back(mk(3'b011, 1'b1, 5, 9'b010000000));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      opcode = tbl[i].op;
      zero   = tbl[i].z;
      pulse_reset();
      repeat (tbl[i].ph) @(posedge clk);
      #1;
      $display("vec %0d: op=%b zero=%b phase=%0d strobes_s=%b strobes_p=%b",
               i, tbl[i].op, tbl[i].z, tbl[i].ph, st_s, st_p);
      check("table_s", {phase_s, st_s}, {3'(tbl[i].ph), tbl[i].exp});
      check("table_p", {phase_p, st_p}, {3'(tbl[i].ph), tbl[i].exp});
    end

    // ---------------- reset mid-cycle ----------------
    @(negedge clk);
    opcode = 3'b010;
    zero   = 1'b0;
    pulse_reset();
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_phase", {phase_s, st_s}, {3'd5, 9'b010000000});
    #2;
    rst_ = 1'b0;
    #1;
    check("mid_reset_s", {phase_s, st_s}, {3'd0, 9'b100000000});
    check("mid_reset_p", {phase_p, st_p}, {3'd0, 9'b100000000});
    @(negedge clk);
    rst_ = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      check("post_reset_seq", {phase_s, st_s}, {3'(i % 8), model(i % 8, 3'b010, 1'b0, 1'b0)});
    end
    $display("mid-cycle reset sequence done");

    // ---------------- HLT: sticky vs pulse ----------------
    @(negedge clk);
    opcode = 3'b000;
    pulse_reset();
    repeat (4) @(posedge clk);
    #1;
    check("hlt_enter_s", {phase_s, st_s}, {3'd4, 9'b000110000});
    check("hlt_enter_p", {phase_p, st_p}, {3'd4, 9'b000110000});
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        opcode = 3'b010;
        zero   = 1'b1;
        #1;
      end
      check("hlt_hold_s", {phase_s, st_s}, {3'd4, 9'b000010000});
      if (i <= 4) begin
        check("hlt_pulse_p", {phase_p, 8'd0, halt_p}, {3'((4 + i) % 8), 8'd0, 1'b0});
      end
    end
    #2;
    rst_ = 1'b0;
    #1;
    check("hlt_reset_s", {phase_s, st_s}, {3'd0, 9'b100000000});
    rst_ = 1'b1;
    $display("halt sequence done");

    // ---------------- randomized run against reference model ----------------
    @(negedge clk);
    pulse_reset();
    ph_s = 0; ph_p = 0; h_s = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      if (!h_s) begin
        if (ph_s == 4 && opcode == 3'b000) h_s = 1'b1;
        else ph_s = (ph_s + 1) % 8;
      end
      ph_p = (ph_p + 1) % 8;
      #1;
      if ($urandom_range(0, 99) == 0) begin
        rst_ = 1'b0;
        ph_s = 0; ph_p = 0; h_s = 1'b0;
      end
      opcode = 3'($urandom_range(0, 7));
      if (opcode == 3'b000 && $urandom_range(0, 9) < 8) opcode = 3'($urandom_range(1, 7));
      zero = 1'($urandom_range(0, 1));
      #1;
      check("rand_s", {phase_s, st_s}, {3'(ph_s), model(ph_s, opcode, zero, h_s)});
      check("rand_p", {phase_p, st_p}, {3'(ph_p), model(ph_p, opcode, zero, 1'b0)});
      rst_ = 1'b1;
    end
    $display("random run done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
